// File: rtl/fxp_mul_arb.sv
// fxp_mul_arb: round-robin arbiter that lets NREQ requesters share a single
// pipelined signed fixed-point multiplier (fxp_mul_pipe, also in this file).
// Each result returns on a shared bus with a one-hot strobe that names its owner.
// Optional feature: define FXP_MUL_ARB_OVF_STICKY_EN to add ovf_sticky[NREQ].
// The multiplier requires WOF <= WIFA+WIFB. It rounds half-up when ROUND != 0
// and saturates to the output range, raising prod_ovf when it does.

module fxp_mul_pipe #(
   parameter int WIIA  = 8,
   parameter int WIFA  = 8,
   parameter int WIIB  = 8,
   parameter int WIFB  = 8,
   parameter int WOI   = 12,
   parameter int WOF   = 6,
   parameter int ROUND = 1,
   parameter int LAT   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIIA+WIFA-1:0]   in_a,
   input  logic [WIIB+WIFB-1:0]   in_b,
   output logic [WOI+WOF-1:0]     prod_out,
   output logic                   prod_ovf
);
   localparam int WA  = WIIA + WIFA;
   localparam int WB  = WIIB + WIFB;
   localparam int PW  = WA + WB;
   localparam int SH  = WIFA + WIFB - WOF;
   localparam int WO  = WOI + WOF;
   localparam int HSH = (SH > 0) ? SH - 1 : 0;
   localparam logic signed [PW:0] ONE  = 1;
   localparam logic signed [PW:0] HALF = (ROUND != 0 && SH > 0) ? (ONE <<< HSH) : '0;
   localparam logic signed [PW:0] OMAX = (ONE <<< (WO - 1)) - ONE;
   localparam logic signed [PW:0] OMIN = -OMAX - ONE;

   logic signed [PW-1:0] a_ext, b_ext, prod_full;
   logic signed [PW:0]   rnd_sum, scaled;
   logic [WO-1:0]        res_d [LAT];
   logic [WO-1:0]        res_q [LAT];
   logic                 ovf_d [LAT];
   logic                 ovf_q [LAT];

   // Full-precision product, half-LSB rounding, saturation, then the delay chain
   always_comb begin
      a_ext     = PW'($signed(in_a));
      b_ext     = PW'($signed(in_b));
      prod_full = a_ext * b_ext;
      rnd_sum   = {prod_full[PW-1], prod_full} + HALF;
      scaled    = rnd_sum >>> SH;
      res_d[0]  = scaled[WO-1:0];
      ovf_d[0]  = 1'b0;
      if (scaled > OMAX) begin
         res_d[0] = OMAX[WO-1:0];
         ovf_d[0] = 1'b1;
      end else if (scaled < OMIN) begin
         res_d[0] = OMIN[WO-1:0];
         ovf_d[0] = 1'b1;
      end
      for (int i = 1; i < LAT; i++) begin
         res_d[i] = res_q[i-1];
         ovf_d[i] = ovf_q[i-1];
      end
   end

   // Pipeline registers; reset flushes them so the output bus reads zero
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) begin
            res_q[i] <= '0;
            ovf_q[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < LAT; i++) begin
            res_q[i] <= res_d[i];
            ovf_q[i] <= ovf_d[i];
         end
      end
   end

   assign prod_out = res_q[LAT-1];
   assign prod_ovf = ovf_q[LAT-1];
endmodule

module fxp_mul_arb #(
   parameter int NREQ    = 4,
   parameter int WIIA    = 8,
   parameter int WIFA    = 8,
   parameter int WIIB    = 8,
   parameter int WIFB    = 8,
   parameter int WOI     = 12,
   parameter int WOF     = 6,
   parameter int ROUND   = 1,
   parameter int MUL_LAT = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NREQ-1:0]             req_valid,
   output logic [NREQ-1:0]             req_ready,
   input  logic [NREQ*(WIIA+WIFA)-1:0] req_ina,
   input  logic [NREQ*(WIIB+WIFB)-1:0] req_inb,
   output logic [NREQ-1:0]             rsp_valid,
   output logic [WOI+WOF-1:0]          rsp_out,
   output logic                        rsp_overflow,
   output logic                        busy
`ifdef FXP_MUL_ARB_OVF_STICKY_EN
   ,
   output logic [NREQ-1:0]             ovf_sticky
`endif
);
   localparam int WA   = WIIA + WIFA;
   localparam int WB   = WIIB + WIFB;
   localparam int WO   = WOI + WOF;
   localparam int PTRW = $clog2(NREQ);

   logic [PTRW-1:0] ptr_q, ptr_d, grant_idx;
   logic [NREQ-1:0] grant;
   logic            xfer;
   int              scan_idx;
   logic [WA-1:0]   a0_q, a0_d;
   logic [WB-1:0]   b0_q, b0_d;
   logic            tag0_valid_q, tag0_valid_d;
   logic [NREQ-1:0] tag0_id_q, tag0_id_d;
   logic            tag_valid_d [MUL_LAT];
   logic            tag_valid_q [MUL_LAT];
   logic [NREQ-1:0] tag_id_d [MUL_LAT];
   logic [NREQ-1:0] tag_id_q [MUL_LAT];
   logic [WO-1:0]   mul_out;
   logic            mul_ovf;
   logic            in_flight;

   // Round-robin search from ptr; the first valid requester wins, nobody while in reset
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      xfer      = 1'b0;
      scan_idx  = 0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = int'(ptr_q) + k;
         if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
         if (!xfer && req_valid[scan_idx]) begin
            xfer            = 1'b1;
            grant[scan_idx] = 1'b1;
            grant_idx       = PTRW'(scan_idx);
         end
      end
      if (rst) begin
         grant = '0;
         xfer  = 1'b0;
      end
   end

   assign req_ready = grant;

   // Next pointer, stage-0 operand capture (zeros as a bubble) and the tag delay line
   always_comb begin
      ptr_d = ptr_q;
      if (xfer) ptr_d = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
      a0_d         = xfer ? req_ina[int'(grant_idx)*WA +: WA] : '0;
      b0_d         = xfer ? req_inb[int'(grant_idx)*WB +: WB] : '0;
      tag0_valid_d = xfer;
      tag0_id_d    = grant;
      tag_valid_d[0] = tag0_valid_q;
      tag_id_d[0]    = tag0_id_q;
      for (int i = 1; i < MUL_LAT; i++) begin
         tag_valid_d[i] = tag_valid_q[i-1];
         tag_id_d[i]    = tag_id_q[i-1];
      end
   end

   // Arbiter pointer, stage 0 and tag line; reset discards everything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q        <= '0;
         a0_q         <= '0;
         b0_q         <= '0;
         tag0_valid_q <= 1'b0;
         tag0_id_q    <= '0;
         for (int i = 0; i < MUL_LAT; i++) begin
            tag_valid_q[i] <= 1'b0;
            tag_id_q[i]    <= '0;
         end
      end else begin
         ptr_q        <= ptr_d;
         a0_q         <= a0_d;
         b0_q         <= b0_d;
         tag0_valid_q <= tag0_valid_d;
         tag0_id_q    <= tag0_id_d;
         for (int i = 0; i < MUL_LAT; i++) begin
            tag_valid_q[i] <= tag_valid_d[i];
            tag_id_q[i]    <= tag_id_d[i];
         end
      end
   end

   fxp_mul_pipe #(
      .WIIA (WIIA), .WIFA (WIFA), .WIIB (WIIB), .WIFB (WIFB),
      .WOI  (WOI),  .WOF  (WOF),  .ROUND(ROUND), .LAT (MUL_LAT)
   ) u_mul (
      .clk      (clk),
      .rst      (rst),
      .in_a     (a0_q),
      .in_b     (b0_q),
      .prod_out (mul_out),
      .prod_ovf (mul_ovf)
   );

   // Response strobe and status; everything is forced quiet while reset is held
   always_comb begin
      in_flight = tag0_valid_q;
      for (int i = 0; i < MUL_LAT; i++) in_flight = in_flight | tag_valid_q[i];
      rsp_valid = '0;
      if (!rst && tag_valid_q[MUL_LAT-1]) rsp_valid = tag_id_q[MUL_LAT-1];
      rsp_out      = rst ? '0 : mul_out;
      rsp_overflow = !rst && mul_ovf;
      busy         = !rst && in_flight;
   end

`ifdef FXP_MUL_ARB_OVF_STICKY_EN
   logic [NREQ-1:0] ovf_sticky_q, ovf_sticky_d;

   // A new transfer clears the owner's bit; an overflowing result sets it (set wins)
   always_comb begin
      ovf_sticky_d = ovf_sticky_q & ~grant;
      if (rsp_overflow) ovf_sticky_d = ovf_sticky_d | rsp_valid;
   end

   // Sticky overflow register
   always_ff @(posedge clk) begin
      if (rst) ovf_sticky_q <= '0;
      else     ovf_sticky_q <= ovf_sticky_d;
   end

   assign ovf_sticky = ovf_sticky_q;
`else
   // This build carries no per-requester overflow history.
`endif
endmodule

// File: tb/tb_fxp_mul_arb.sv
// Directed testbench for fxp_mul_arb (NREQ=4, Q8.8 x Q8.8 -> Q12.6, MUL_LAT=2).
// Define FXP_MUL_ARB_OVF_STICKY_EN to also exercise ovf_sticky.

module tb_fxp_mul_arb;
   localparam int NREQ    = 4;
   localparam int WA      = 16;
   localparam int WB      = 16;
   localparam int WO      = 18;
   localparam int MUL_LAT = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*WA-1:0] req_ina;
   logic [NREQ*WB-1:0] req_inb;
   logic [NREQ-1:0]   rsp_valid;
   logic [WO-1:0]     rsp_out;
   logic              rsp_overflow;
   logic              busy;
`ifdef FXP_MUL_ARB_OVF_STICKY_EN
   logic [NREQ-1:0]   ovf_sticky;
`endif

   int checkCount = 0;
   int errorCount = 0;

   always #5 clk = ~clk;

   fxp_mul_arb #(
      .NREQ(NREQ), .WIIA(8), .WIFA(8), .WIIB(8), .WIFB(8),
      .WOI(12), .WOF(6), .ROUND(1), .MUL_LAT(MUL_LAT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_ina      (req_ina),
      .req_inb      (req_inb),
      .rsp_valid    (rsp_valid),
      .rsp_out      (rsp_out),
      .rsp_overflow (rsp_overflow),
      .busy         (busy)
`ifdef FXP_MUL_ARB_OVF_STICKY_EN
      ,
      .ovf_sticky   (ovf_sticky)
`endif
   );

   // Advance one clock and settle just after the rising edge
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // One comparison: count it, and on mismatch report tag, observed and expected
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) else begin
         errorCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Send one operand pair from a single requester and check its result and timing
   task automatic applyStimulus(input int id, input logic [15:0] a, input logic [15:0] b,
                                input logic [17:0] expOut, input logic expOvf);
      req_ina[id*WA +: WA] = a;
      req_inb[id*WB +: WB] = b;
      req_valid = NREQ'(1) << id;
      #1;
      checkOutput("single_ready", 32'(req_ready), 32'(NREQ'(1) << id));
      stepCycle();
      req_valid = '0;
      checkOutput("single_busy", 32'(busy), 32'd1);
      repeat (MUL_LAT) begin
         checkOutput("single_early", 32'(rsp_valid), 32'd0);
         stepCycle();
      end
      checkOutput("single_rsp_valid", 32'(rsp_valid), 32'(NREQ'(1) << id));
      checkOutput("single_rsp_out", 32'(rsp_out), 32'(expOut));
      checkOutput("single_rsp_ovf", 32'(rsp_overflow), 32'(expOvf));
      stepCycle();
      checkOutput("single_rsp_done", 32'(rsp_valid), 32'd0);
      checkOutput("single_busy_done", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [NREQ-1:0] expRsp;
      int g;
      $display("[TB] start");
      rst = 1'b1;
      req_valid = '0;
      req_ina = '0;
      req_inb = '0;
      repeat (2) stepCycle();

      // Reset state, with every requester asking for service
      req_valid = '1;
      #1;
      checkOutput("rst_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_rsp_out", 32'(rsp_out), 32'd0);
      checkOutput("rst_rsp_ovf", 32'(rsp_overflow), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      req_valid = '0;
      stepCycle();
      rst = 1'b0;

      // Single op: 1.5 * 2.0 = 3.0
      applyStimulus(0, 16'h0180, 16'h0200, 18'h000C0, 1'b0);

      // Reset so the pointer restarts at 0 for the round-robin run
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;

      // All four valid for 8 cycles: requester i sends (i+1).0 * 2.0
      for (int i = 0; i < NREQ; i++) begin
         req_ina[i*WA +: WA] = 16'((i + 1) << 8);
         req_inb[i*WB +: WB] = 16'h0200;
      end
      for (int k = 0; k < 12; k++) begin
         req_valid = (k < 8) ? '1 : '0;
         #1;
         if (k < 8) checkOutput("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
         else       checkOutput("rr_ready_idle", 32'(req_ready), 32'd0);
         expRsp = '0;
         if (k >= 3 && k - 3 < 8) expRsp = NREQ'(1) << ((k - 3) % 4);
         checkOutput("rr_rsp_valid", 32'(rsp_valid), 32'(expRsp));
         if (expRsp != '0) begin
            g = (k - 3) % 4;
            checkOutput("rr_rsp_out", 32'(rsp_out), 32'((g + 1) * 128));
         end
         if (k >= 9) checkOutput("b2b_busy", 32'(busy), (k <= 10) ? 32'd1 : 32'd0);
         stepCycle();
      end

      // Requester 1 alone moves ptr to 2: 2.0 * 2.0 = 4.0
      applyStimulus(1, 16'h0200, 16'h0200, 18'h00100, 1'b0);
      // Requesters 1 and 3 with ptr = 2: grant 3, then 1
      req_valid = 4'b1010;
      #1;
      checkOutput("ptr2_first", 32'(req_ready), 32'b1000);
      stepCycle();
      checkOutput("ptr2_second", 32'(req_ready), 32'b0010);
      stepCycle();
      req_valid = '1;
      #1;
      checkOutput("ptr2_end", 32'(req_ready), 32'b0100);
      req_valid = '0;
      stepCycle();
      checkOutput("ptr2_rsp_first", 32'(rsp_valid), 32'b1000);
      stepCycle();
      checkOutput("ptr2_rsp_second", 32'(rsp_valid), 32'b0010);
      stepCycle();
      checkOutput("ptr2_rsp_idle", 32'(rsp_valid), 32'd0);

      // Overflow, sign, and rounding corners
      applyStimulus(2, 16'h7F00, 16'h7F00, 18'h1FFFF, 1'b1);
`ifdef FXP_MUL_ARB_OVF_STICKY_EN
      checkOutput("sticky_set", 32'(ovf_sticky), 32'b0100);
`endif
      applyStimulus(3, 16'h8000, 16'h7F00, 18'h20000, 1'b1);
`ifdef FXP_MUL_ARB_OVF_STICKY_EN
      checkOutput("sticky_hold", 32'(ovf_sticky), 32'b1100);
`endif
      applyStimulus(0, 16'hFE80, 16'h0200, 18'h3FF40, 1'b0);
      applyStimulus(1, 16'h0002, 16'h0100, 18'h00001, 1'b0);
      applyStimulus(1, 16'h0001, 16'h0100, 18'h00000, 1'b0);
      applyStimulus(2, 16'h0100, 16'h0100, 18'h00040, 1'b0);
`ifdef FXP_MUL_ARB_OVF_STICKY_EN
      checkOutput("sticky_clear", 32'(ovf_sticky), 32'b1000);
`endif

      // Reset with two ops in flight (ptr is 3 here, so 1 then 2 are granted)
      req_valid = 4'b0110;
      #1;
      checkOutput("flight_first", 32'(req_ready), 32'b0010);
      stepCycle();
      checkOutput("flight_second", 32'(req_ready), 32'b0100);
      stepCycle();
      rst = 1'b1;
      req_valid = '1;
      #1;
      checkOutput("midrst_ready", 32'(req_ready), 32'd0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("midrst_rsp_out", 32'(rsp_out), 32'd0);
      req_valid = '0;
      stepCycle();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         checkOutput("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
         checkOutput("postrst_busy", 32'(busy), 32'd0);
         stepCycle();
      end
      req_valid = '1;
      #1;
      checkOutput("postrst_grant", 32'(req_ready), 32'b0001);
      req_valid = '0;
      stepCycle();

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end
endmodule
